scr1_imem_cmd_monitor: RTL

SCR1_IMEM_CMD_MONITOR -- requirements
Module: scr1_imem_cmd_monitor

---
 rtl/scr1_imem_cmd_monitor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/scr1_imem_cmd_monitor.sv
// Instruction-fetch monitor: per-channel mask/value matching on IMEM responses,
// saturating hit counters, and a timestamped capture FIFO with drop accounting.
module scr1_imem_cmd_monitor #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [1:0]              imem_resp,
    input  logic [31:0]             imem_rdata,
    input  logic [31:0]             curr_pc,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*32-1:0]    match_mask,
    input  logic [NUM_CH*32-1:0]    match_value,
    input  logic                    log_pop,
    output logic                    log_valid,
    output logic [31:0]             log_pc,
    output logic [31:0]             log_instr,
    output logic [2:0]              log_ch,
    output logic [31:0]             log_ts,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    ovf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [31:0]       ts_q;
    logic [NUM_CH-1:0] hit;
    logic              any_hit;
    logic [2:0]        win_ch;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    logic [31:0]       pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       ts_mem    [DEPTH];
    logic [2:0]        ch_mem    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    logic push, pop, full, wr_en, drop;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (imem_resp == 2'b01) && ch_en[i] &&
                     ((imem_rdata & match_mask[32*i +: 32]) ==
                      (match_value[32*i +: 32] & match_mask[32*i +: 32]));
        end
    end

    // Lowest hitting index wins the record's channel field
    always_comb begin
        win_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) win_ch = 3'(i);
        end
    end

    assign any_hit = |hit;
    assign push    = any_hit && !clr;
    assign pop     = log_pop && (count != '0) && !clr;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) cnt_q[i] <= sat_inc_cnt(cnt_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
            if (drop) begin
                drop_cnt <= sat_inc_drop(drop_cnt);
                ovf      <= 1'b1;
            end
        end
    end

    // Record storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= curr_pc;
            instr_mem[wr_ptr] <= imem_rdata;
            ch_mem[wr_ptr]    <= win_ch;
            ts_mem[wr_ptr]    <= ts_q;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign log_valid = (count != '0);
    assign log_pc    = log_valid ? pc_mem[rd_ptr]    : '0;
    assign log_instr = log_valid ? instr_mem[rd_ptr] : '0;
    assign log_ch    = log_valid ? ch_mem[rd_ptr]    : '0;
    assign log_ts    = log_valid ? ts_mem[rd_ptr]    : '0;

endmodule
